regfile_writeback_queue: RTL and testbench
==========================================

# regfile_writeback_queue

Write-back initiator for the 8×8-bit register file. Collects results from two producers, the ALU and the load unit, and queues them in order in a small buffer. Drains one entry per cycle into the register file's single write port. Also reports whether a queued write is pending for each of the two register-file read addresses, so decode can stall on RAW hazards.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2–8.
- DATA_W, 8: result width; equals the register file data width.
- ADDR_W, 3: register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted this cycle when ld_valid is also high.
- ld_reg  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load result.
- rf_write_enable  out  1  register-file write strobe.
- rf_write_reg  out  ADDR_W  register-file write address.
- rf_write_data  out  DATA_W  register-file write data.
- qry_reg1, qry_reg2  in  ADDR_W  addresses currently being read by decode.
- pending1, pending2  out  1  a queued entry targets qry_reg1 or qry_reg2, respectively.
- count  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Circular buffer with head and tail pointers, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus a count register.
- free = DEPTH − count, using the registered count. A pop in the same cycle does not free a slot for enqueue.
- Readiness:
  - ld_ready = (free ≥ 1).
  - alu_ready = (free ≥ 2) or (free = 1 and not ld_valid). The load result has priority.
  - The ready signals do not depend on the producers' own valid signals, except alu_ready's dependence on ld_valid.
- Enqueue order when both results are accepted in one cycle: the load entry goes at tail and the ALU entry at tail+1. A later write to the same register therefore always lands later, and the last write wins.
- Drain:
  - rf_write_enable = (count ≠ 0).
  - rf_write_reg and rf_write_data come from the head entry.
  - The head pops on every clock edge where count ≠ 0. The register file never back-pressures.
- count_next = count + pushes − pop, where pushes is 0, 1 or 2 and pop is 0 or 1. count never exceeds DEPTH.
- pendingN is the OR over all valid entries of (entry.reg == qry_regN). It is combinational. It includes the head entry being written this cycle.
- No special handling for register 0; it is written like any other register.
- When empty, rf_write_reg and rf_write_data hold the last head value. They are don't-care and must not be checked.

## Timing
- Reset (asynchronous assert, synchronous release by the system): head = tail = count = 0. The outputs then settle to rf_write_enable = 0, pending1 = pending2 = 0, alu_ready = ld_ready = 1, and count = 0. Entry storage is not reset.
- Latency:
  - A result accepted at edge N has rf_write_enable high during cycle N→N+1 if the queue was empty.
  - The register file captures it at edge N+1.
  - While queued, the entry is visible on pendingN from cycle N→N+1 until the edge at which it is written.
- Throughput: one write per cycle. Two accepts per cycle are allowed only while free ≥ 2.
- Full (count = DEPTH): both readies are low. The pop at that edge makes readies high in the following cycle.
- Reset asserted mid-drain: the queue empties immediately and queued writes are lost. rf_write_enable drops asynchronously.

## Structure
- Shared package mini_cpu_pkg:
  - REG_ADDR_W = 3 and REG_DATA_W = 8.
  - typedef wb_entry_t {reg addr, data}, shared with the register file and decode.
- Sub-module wb_fifo:
  - Dual-push, single-pop circular buffer of wb_entry_t.
  - Exposes count and the array of valid-entry addresses for the pending compare.
  - The top level holds the arbitration and the hazard compare.

## Test plan
- Reset, then a single ALU push of reg 3 / 0x5A → rf_write_enable high for exactly one cycle with reg 3 and 0x5A. count goes 0→1→0. pending is 1 for qry 3 during that cycle.
- ALU and load valid together on an empty queue, ld = r2/0x11 and alu = r2/0x22 → both accepted. Writes occur on consecutive cycles, 0x11 then 0x22. r2's final value is 0x22.
- Fill: 4 single pushes with the drain active → count never exceeds 4. Both producers valid every cycle → readies follow the free-slot rules, and exactly one accept per cycle once at steady state.
- count = 3 (free = 1) with both valid → ld_ready = 1 and alu_ready = 0. The load is enqueued and the ALU stalls one cycle.
- Pending: queue holds r5 and r1 → qry 5 and 1 give pending = 1, qry 4 gives 0. Both drop to 0 after the respective writes.
- Assert rst_n low while count = 3 → rf_write_enable goes 0 without a clock edge. After release, count = 0 and no stale writes are issued.

Source files
------------

// File: rtl/mini_cpu_pkg.sv
// rtl/mini_cpu_pkg.sv - shared register-file widths and write-back entry type
package mini_cpu_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - dual-push single-pop circular buffer of write-back entries
module wb_fifo
    import mini_cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push0,
    input  wb_entry_t                           push0_entry,
    input  logic                                push1,
    input  wb_entry_t                           push1_entry,
    input  logic                                pop,
    output wb_entry_t                           head_entry,
    output logic [$clog2(DEPTH):0]              count,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH*REG_ADDR_W-1:0]         entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail1;
    logic [1:0]       n_push;

    // push1 lands directly behind push0 when both are present, otherwise at tail
    assign n_push = {1'b0, push0} + {1'b0, push1};
    assign tail1  = tail + PTR_W'(push0);

    // entry storage is deliberately not reset; validity comes from head/count
    always_ff @(posedge clk) begin
        if (push0) begin
            mem[tail] <= push0_entry;
        end
        if (push1) begin
            mem[tail1] <= push1_entry;
        end
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTR_W'(n_push);
            head  <= head + PTR_W'(pop);
            count <= count + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

    assign head_entry = mem[head];

    // an entry is live when its distance from head is below the occupancy
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        entry_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - head;
            entry_valid[i] = ({1'b0, offset} < count);
            entry_addr[i*REG_ADDR_W +: REG_ADDR_W] = mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - ALU/load write-back arbitration, drain and RAW hazard report
module regfile_writeback_queue
    import mini_cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_reg,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        ld_reg,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     rf_write_enable,
    output logic [ADDR_W-1:0]        rf_write_reg,
    output logic [DATA_W-1:0]        rf_write_data,
    input  logic [ADDR_W-1:0]        qry_reg1,
    input  logic [ADDR_W-1:0]        qry_reg2,
    output logic                     pending1,
    output logic                     pending2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t                   ld_entry;
    wb_entry_t                   alu_entry;
    wb_entry_t                   head_entry;
    logic [CNT_W-1:0]            free;
    logic                        ld_push;
    logic                        alu_push;
    logic                        pop;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH*REG_ADDR_W-1:0] entry_addr;

    // free space comes from the registered count only; this cycle's pop is not credited
    assign free      = CNT_W'(DEPTH) - count;
    assign ld_ready  = (free != '0);
    assign alu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !ld_valid);

    assign ld_push  = ld_valid && ld_ready;
    assign alu_push = alu_valid && alu_ready;
    assign pop      = (count != '0);

    assign ld_entry.addr  = ld_reg;
    assign ld_entry.data  = ld_data;
    assign alu_entry.addr = alu_reg;
    assign alu_entry.data = alu_data;

    // load takes the first slot so a same-cycle ALU write to the same register wins
    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0       (ld_push),
        .push0_entry (ld_entry),
        .push1       (alu_push),
        .push1_entry (alu_entry),
        .pop         (pop),
        .head_entry  (head_entry),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    assign rf_write_enable = pop;
    assign rf_write_reg    = head_entry.addr;
    assign rf_write_data   = head_entry.data;

    // hazard report covers every live entry, including the head being written now
    always_comb begin
        pending1 = 1'b0;
        pending2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == qry_reg1)) begin
                pending1 = 1'b1;
            end
            if (entry_valid[i] && (entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == qry_reg2)) begin
                pending2 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - scoreboard bench for regfile_writeback_queue
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_valid;
    logic       alu_ready;
    logic [2:0] alu_reg;
    logic [7:0] alu_data;
    logic       ld_valid;
    logic       ld_ready;
    logic [2:0] ld_reg;
    logic [7:0] ld_data;
    logic       rf_write_enable;
    logic [2:0] rf_write_reg;
    logic [7:0] rf_write_data;
    logic [2:0] qry_reg1;
    logic [2:0] qry_reg2;
    logic       pending1;
    logic       pending2;
    logic [2:0] count;

    typedef struct {
        int r;
        int d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   mdl_count = 0;

    regfile_writeback_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (8),
        .ADDR_W (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_reg         (alu_reg),
        .alu_data        (alu_data),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_reg          (ld_reg),
        .ld_data         (ld_data),
        .rf_write_enable (rf_write_enable),
        .rf_write_reg    (rf_write_reg),
        .rf_write_data   (rf_write_data),
        .qry_reg1        (qry_reg1),
        .qry_reg2        (qry_reg2),
        .pending1        (pending1),
        .pending2        (pending2),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && rf_write_enable) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_reg", int'(rf_write_reg), mon_e.r);
                chk("wr_data", int'(rf_write_data), mon_e.d);
            end
        end
    end

    // one clock of stimulus; ep1/ep2 < 0 skip the pending compare
    task automatic cycle(input bit lv, input int lr, input int ldd,
                         input bit av, input int ar, input int ad,
                         input int q1, input int ep1, input int q2, input int ep2);
        int  free;
        bit  lexp;
        bit  aexp;
        int  pushes;
        ld_valid  = lv;
        ld_reg    = lr[2:0];
        ld_data   = ldd[7:0];
        alu_valid = av;
        alu_reg   = ar[2:0];
        alu_data  = ad[7:0];
        qry_reg1  = q1[2:0];
        qry_reg2  = q2[2:0];
        free = DEPTH - mdl_count;
        lexp = (free >= 1);
        aexp = (free >= 2) || (free == 1 && !lv);
        @(negedge clk);
        chk("count", int'(count), mdl_count);
        chk("wen", int'(rf_write_enable), int'(mdl_count != 0));
        chk("ld_ready", int'(ld_ready), int'(lexp));
        chk("alu_ready", int'(alu_ready), int'(aexp));
        if (ep1 >= 0) chk("pending1", int'(pending1), ep1);
        if (ep2 >= 0) chk("pending2", int'(pending2), ep2);
        @(posedge clk);
        pushes = 0;
        if (lv && lexp) begin
            sb.push_back('{r: lr, d: ldd});
            pushes++;
        end
        if (av && aexp) begin
            sb.push_back('{r: ar, d: ad});
            pushes++;
        end
        mdl_count = mdl_count + pushes - ((mdl_count != 0) ? 1 : 0);
        #1;
    endtask

    task automatic idle(input int q1, input int ep1, input int q2, input int ep2);
        cycle(1'b0, 0, 0, 1'b0, 0, 0, q1, ep1, q2, ep2);
    endtask

    initial begin
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_reg    = '0;
        ld_data   = '0;
        qry_reg1  = 3'd0;
        qry_reg2  = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_wen", int'(rf_write_enable), 0);
        chk("rst_pending1", int'(pending1), 0);
        chk("rst_pending2", int'(pending2), 0);
        chk("rst_ld_ready", int'(ld_ready), 1);
        chk("rst_alu_ready", int'(alu_ready), 1);
        rst_n = 1'b1;

        // single ALU write r3 / 0x5A
        cycle(1'b0, 0, 0, 1'b1, 3, 'h5A, 3, 0, 4, 0);
        idle(3, 1, 4, 0);
        idle(3, 0, 4, 0);

        // simultaneous load r2/0x11 and ALU r2/0x22: load written first
        cycle(1'b1, 2, 'h11, 1'b1, 2, 'h22, 2, 0, 3, 0);
        idle(2, 1, 3, 0);
        idle(2, 1, 3, 0);
        idle(2, 0, 3, 0);

        // four single pushes with the drain running
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 0, 0, 1'b1, i + 4, 'h30 + i, -1, -1, -1, -1);
        end
        idle(-1, -1, -1, -1);

        // both producers every cycle: count reaches 3, then loads only
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, i & 7, 'h40 + i, 1'b1, (i + 1) & 7, 'h80 + i, -1, -1, -1, -1);
        end
        repeat (4) idle(-1, -1, -1, -1);

        // pending: queue holds r5 then r1
        cycle(1'b1, 5, 'h55, 1'b1, 1, 'h15, 5, 0, 1, 0);
        idle(5, 1, 4, 0);
        idle(5, 0, 1, 1);
        idle(1, 0, 5, 0);

        // reset while three writes are queued
        cycle(1'b1, 6, 'hA1, 1'b1, 7, 'hA2, -1, -1, -1, -1);
        cycle(1'b1, 6, 'hB1, 1'b1, 7, 'hB2, -1, -1, -1, -1);
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
        qry_reg1  = 3'd6;
        qry_reg2  = 3'd7;
        chk("pre_rst_count", int'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wen", int'(rf_write_enable), 0);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_pending1", int'(pending1), 0);
        chk("async_rst_pending2", int'(pending2), 0);
        sb.delete();
        mdl_count = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) idle(6, 0, 7, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
